dac_wave_gen: RTL and testbench

DAC_WAVE_GEN -- requirements
Module: dac_wave_gen

---
 rtl/dac_wave_gen_if.sv | 10 +
 rtl/dac_wave_gen.sv | 124 ++++++++++++
 tb/tb_dac_wave_gen.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/dac_wave_gen_if.sv
// Sample stream between the waveform generator and the DAC serialiser stage.
// The generator is the master; the DAC stage returns sample_ready.
interface dac_wave_gen_if;
    logic [7:0] sample_out;
    logic       sample_valid;
    logic       sample_ready;

    modport master (output sample_out, output sample_valid, input sample_ready);
    modport slave  (input sample_out, input sample_valid, output sample_ready);
endinterface

// File: rtl/dac_wave_gen.sv
// DAC waveform generator: phase-accumulator triangle/saw/square or host FIFO
// samples, delivered one per load/hold handshake with a one-cycle bubble.
module dac_wave_gen #(
    parameter int PHASE_W    = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic               clk_in,
    input  logic               rst_n,
    input  logic [1:0]         wave_sel,
    input  logic [PHASE_W-1:0] freq_step,
    input  logic               host_wr,
    input  logic [7:0]         host_data,
    input  logic               clr_flags,
    dac_wave_gen_if.master     smp,
    output logic               host_full,
    output logic [2:0]         fifo_level,
    output logic               overflow,
    output logic [7:0]         underrun_cnt
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    typedef enum logic {S_LOAD, S_HOLD} state_t;

    state_t             state;
    logic [PHASE_W-1:0] phase;
    logic [7:0]         last_host;
    logic [7:0]         fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [2:0]         level;

    logic       fifo_empty;
    logic       fifo_full;
    logic       host_load;
    logic       do_push;
    logic       do_pop;
    logic       underrun;
    logic [7:0] p;
    logic [7:0] wave_val;

    assign fifo_empty = (level == 3'd0);
    assign fifo_full  = (level == 3'(FIFO_DEPTH));
    assign host_full  = fifo_full;
    assign fifo_level = level;

    assign host_load = (state == S_LOAD) && (wave_sel == 2'd3);
    assign do_pop    = host_load && !fifo_empty;
    assign underrun  = host_load && fifo_empty;
    assign do_push   = host_wr && !fifo_full;

    assign p = phase[PHASE_W-1 -: 8];

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
    endfunction

    always_comb begin
        // NOTE: give every always_comb output a default first so no path can infer a latch.
        wave_val = p;
        case (wave_sel)
            2'd0:    wave_val = p[7] ? ~{p[6:0], 1'b0} : {p[6:0], 1'b0};
            2'd2:    wave_val = p[7] ? 8'hFF : 8'h00;
            2'd3:    wave_val = fifo_empty ? last_host : fifo_mem[rd_ptr];
            default: wave_val = p;
        endcase
    end

    // NOTE: storage is not reset; pointers and level alone say which entries are valid.
    always_ff @(posedge clk_in) begin
        if (do_push) fifo_mem[wr_ptr] <= host_data;
    end

    // NOTE: all sequential state uses non-blocking assignment so every register sees pre-edge values.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state            <= S_LOAD;
            smp.sample_out   <= 8'h00;
            smp.sample_valid <= 1'b0;
            phase            <= '0;
            last_host        <= 8'h00;
            rd_ptr           <= '0;
            wr_ptr           <= '0;
            level            <= 3'd0;
            overflow         <= 1'b0;
            underrun_cnt     <= 8'h00;
        end else begin
            case (state)
                S_LOAD: begin
                    smp.sample_out   <= wave_val;
                    smp.sample_valid <= 1'b1;
                    state            <= S_HOLD;
                    // Host mode freezes the accumulator so synthetic modes resume in phase.
                    if (wave_sel != 2'd3) phase <= phase + freq_step;
                    if (do_pop) last_host <= wave_val;
                end
                S_HOLD: begin
                    if (smp.sample_ready) begin
                        smp.sample_valid <= 1'b0;
                        state            <= S_LOAD;
                    end
                end
                default: state <= S_LOAD;
            endcase

            if (do_push) wr_ptr <= ptr_next(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_next(rd_ptr);

            case ({do_push, do_pop})
                2'b10:   level <= level + 3'd1;
                2'b01:   level <= level - 3'd1;
                default: level <= level;
            endcase

            // A full FIFO drops the write even if a pop frees a slot on the same edge.
            if (clr_flags)                overflow <= 1'b0;
            else if (host_wr && fifo_full) overflow <= 1'b1;

            if (clr_flags)                                underrun_cnt <= 8'h00;
            else if (underrun && underrun_cnt != 8'hFF)   underrun_cnt <= underrun_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_dac_wave_gen.sv
// Scoreboarded bench for dac_wave_gen: stimulus queues expected samples,
// a negedge monitor pops and compares on every accepted sample.
module tb_dac_wave_gen;

    logic        clk_in = 1'b0;
    logic        rst_n;
    logic [1:0]  wave_sel;
    logic [15:0] freq_step;
    logic        host_wr;
    logic [7:0]  host_data;
    logic        clr_flags;
    logic        host_full;
    logic [2:0]  fifo_level;
    logic        overflow;
    logic [7:0]  underrun_cnt;

    dac_wave_gen_if sif ();

    dac_wave_gen #(.PHASE_W(16), .FIFO_DEPTH(4)) dut (
        .clk_in       (clk_in),
        .rst_n        (rst_n),
        .wave_sel     (wave_sel),
        .freq_step    (freq_step),
        .host_wr      (host_wr),
        .host_data    (host_data),
        .clr_flags    (clr_flags),
        .smp          (sif),
        .host_full    (host_full),
        .fifo_level   (fifo_level),
        .overflow     (overflow),
        .underrun_cnt (underrun_cnt)
    );

    always #50 clk_in = ~clk_in;

    int         n_pass   = 0;
    int         n_checks = 0;
    logic [7:0] exp_q[$];
    bit         prev_hs  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Monitor: an accepted sample is valid&&ready at the negedge before the accepting edge.
    initial begin
        logic [7:0] e;
        forever begin
            @(negedge clk_in);
            if (rst_n) begin
                if (prev_hs) check("bubble_valid", 32'(sif.sample_valid), 32'd0);
                prev_hs = 1'b0;
                if (sif.sample_valid && sif.sample_ready) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        $display("FAIL unexpected_sample: got %0h expected none at %0t", sif.sample_out, $time);
                    end else begin
                        e = exp_q.pop_front();
                        check("sample", 32'(sif.sample_out), 32'(e));
                    end
                    prev_hs = 1'b1;
                end
            end
        end
    end

    // Releases ready until the scoreboard empties, then drops it right after the accepting edge.
    task automatic drain();
        int cyc = 0;
        sif.sample_ready = 1'b1;
        while (exp_q.size() != 0 && cyc < 4000) begin
            @(posedge clk_in);
            cyc++;
        end
        #1;
        sif.sample_ready = 1'b0;
        if (exp_q.size() != 0) begin
            n_checks++;
            $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic host_write(input logic [7:0] d, input logic clr);
        host_wr   = 1'b1;
        host_data = d;
        clr_flags = clr;
        step();
        host_wr   = 1'b0;
        clr_flags = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] tri_a [7];
        logic [7:0] tri_b [7];
        tri_a = '{8'h02, 8'h06, 8'h86, 8'hF9, 8'h79, 8'h06, 8'h86};
        tri_b = '{8'h00, 8'h00, 8'h80, 8'hFF, 8'h7F, 8'h00, 8'h80};

        rst_n = 1'b0;
        wave_sel = 2'd1;
        freq_step = 16'h0100;
        host_wr = 1'b0;
        host_data = 8'h00;
        clr_flags = 1'b0;
        sif.sample_ready = 1'b0;
        #1;
        check("rst_sample_out", 32'(sif.sample_out), 32'h00);
        check("rst_valid", 32'(sif.sample_valid), 32'd0);
        check("rst_level", 32'(fifo_level), 32'd0);
        check("rst_full", 32'(host_full), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_underrun", 32'(underrun_cnt), 32'd0);

        @(negedge clk_in);
        rst_n = 1'b1;
        step();
        check("first_valid", 32'(sif.sample_valid), 32'd1);
        check("first_sample", 32'(sif.sample_out), 32'h00);

        // Sawtooth at one LSB of p per sample, including the FF->00 wrap.
        for (int k = 0; k < 258; k++) exp_q.push_back(8'(k));
        drain();
        step();
        check("saw_held", 32'(sif.sample_out), 32'h02);

        // Long hold with a mid-hold mode change; the held sample must not move.
        for (int i = 0; i < 50; i++) begin
            @(negedge clk_in);
            check("hold_out", 32'(sif.sample_out), 32'h02);
            check("hold_valid", 32'(sif.sample_valid), 32'd1);
            if (i == 25) begin
                wave_sel  = 2'd0;
                freq_step = 16'h4000;
            end
        end
        step();
        for (int i = 0; i < 7; i++) exp_q.push_back(tri_a[i]);
        drain();
        step();
        check("tri_held", 32'(sif.sample_out), 32'hF9);

        // Host mode: fill past full, then drain into underruns.
        wave_sel = 2'd3;
        host_write(8'h11, 1'b0);
        host_write(8'h22, 1'b0);
        host_write(8'h33, 1'b0);
        host_write(8'h44, 1'b0);
        host_write(8'h55, 1'b0);
        check("fill_level", 32'(fifo_level), 32'd4);
        check("fill_full", 32'(host_full), 32'd1);
        check("fill_overflow", 32'(overflow), 32'd1);
        exp_q.push_back(8'hF9);
        exp_q.push_back(8'h11);
        exp_q.push_back(8'h22);
        exp_q.push_back(8'h33);
        exp_q.push_back(8'h44);
        exp_q.push_back(8'h44);
        exp_q.push_back(8'h44);
        drain();
        step();
        check("under_held", 32'(sif.sample_out), 32'h44);
        check("under_cnt", 32'(underrun_cnt), 32'd3);
        check("under_level", 32'(fifo_level), 32'd0);
        check("under_full", 32'(host_full), 32'd0);

        // clr_flags beats a same-edge dropped write.
        host_write(8'hA1, 1'b0);
        host_write(8'hA2, 1'b0);
        host_write(8'hA3, 1'b0);
        host_write(8'hA4, 1'b0);
        check("refill_level", 32'(fifo_level), 32'd4);
        check("sticky_overflow", 32'(overflow), 32'd1);
        host_write(8'hA5, 1'b1);
        check("clr_overflow", 32'(overflow), 32'd0);
        check("clr_underrun", 32'(underrun_cnt), 32'd0);
        check("clr_level", 32'(fifo_level), 32'd4);
        host_write(8'hA6, 1'b0);
        check("drop_overflow", 32'(overflow), 32'd1);
        clr_flags = 1'b1;
        step();
        clr_flags = 1'b0;
        check("clr_alone", 32'(overflow), 32'd0);

        // Accepted write on the same edge as a pop keeps the level.
        exp_q.push_back(8'h44);
        exp_q.push_back(8'hA1);
        drain();
        check("pre_wp_level", 32'(fifo_level), 32'd3);
        host_write(8'hB1, 1'b0);
        check("wp_level", 32'(fifo_level), 32'd3);
        check("wp_sample", 32'(sif.sample_out), 32'hA2);
        exp_q.push_back(8'hA2);
        drain();
        step();
        check("pre_rst_sample", 32'(sif.sample_out), 32'hA3);
        check("pre_rst_level", 32'(fifo_level), 32'd2);

        // Asynchronous reset in the middle of a hold.
        #10;
        rst_n = 1'b0;
        #1;
        check("mid_rst_sample", 32'(sif.sample_out), 32'h00);
        check("mid_rst_valid", 32'(sif.sample_valid), 32'd0);
        check("mid_rst_level", 32'(fifo_level), 32'd0);
        check("mid_rst_full", 32'(host_full), 32'd0);
        check("mid_rst_overflow", 32'(overflow), 32'd0);
        check("mid_rst_underrun", 32'(underrun_cnt), 32'd0);
        #10;
        rst_n = 1'b1;
        step();
        check("post_rst_valid", 32'(sif.sample_valid), 32'd1);
        check("post_rst_sample", 32'(sif.sample_out), 32'h00);
        check("post_rst_underrun", 32'(underrun_cnt), 32'd1);

        // Triangle from phase zero at a quarter-cycle step.
        wave_sel  = 2'd0;
        freq_step = 16'h4000;
        for (int i = 0; i < 7; i++) exp_q.push_back(tri_b[i]);
        drain();
        step();
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
